// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: one result bit per cycle, shift-add multiply, restoring divide.
// Latency: accept to done = N+3 cycles (N = 64, or 32 for W ops); division special cases take 3.
// Backpressure: none; start is ignored while busy, kill aborts to IDLE, done is a single-cycle pulse.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);

    localparam int HALF = XLEN / 2;

    // funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic                word_q;
    logic [XLEN-1:0]     a_raw;
    logic [XLEN-1:0]     b_raw;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     b_reg;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   prod;      // multiply: {acc, multiplier}; divide: {remainder, dividend/quotient}
    logic                neg;       // negate the selected result in FIX
    logic [6:0]          cnt;

    logic                accept;
    logic                signed_a, signed_b;
    logic [XLEN-1:0]     ext_a, ext_b, abs_a, abs_b, min_v;
    logic                sign_a, sign_b, neg_prep;
    logic                div_zero, div_ovf;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_trial;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [2*XLEN-1:0]   prod_step;
    logic [2*XLEN-1:0]   mul_raw, mul_s;
    logic [XLEN-1:0]     quo_s, rem_s, res_sel, res_fin;

    // W ops only exist for MUL and the divides; other ops with is_word run full width
    logic word_eff;
    assign word_eff = is_word & ((op == OP_MUL) | op[2]);

    assign accept = start & ~kill & ((state == S_IDLE) | (state == S_DONE));

    // Operand conditioning, sign bookkeeping and special-case detection for PREP
    always_comb begin
        signed_a = (op_q == OP_MUL) | (op_q == OP_MULH) | (op_q == OP_MULHSU) |
                   (op_q == OP_DIV) | (op_q == OP_REM);
        signed_b = (op_q == OP_MUL) | (op_q == OP_MULH) | (op_q == OP_DIV) | (op_q == OP_REM);
        ext_a    = a_raw;
        ext_b    = b_raw;
        if (word_q) begin
            ext_a = {{HALF{signed_a & a_raw[HALF-1]}}, a_raw[HALF-1:0]};
            ext_b = {{HALF{signed_b & b_raw[HALF-1]}}, b_raw[HALF-1:0]};
        end
        sign_a = signed_a & ext_a[XLEN-1];
        sign_b = signed_b & ext_b[XLEN-1];
        abs_a  = sign_a ? (~ext_a + 1'b1) : ext_a;
        abs_b  = sign_b ? (~ext_b + 1'b1) : ext_b;
        case (op_q)
            OP_MUL, OP_MULH, OP_DIV: neg_prep = sign_a ^ sign_b;
            OP_MULHSU, OP_REM:       neg_prep = sign_a;
            default:                 neg_prep = 1'b0;
        endcase
        min_v    = word_q ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = op_q[2] & (ext_b == '0);
        div_ovf  = op_q[2] & ~op_q[0] & (ext_a == min_v) & (ext_b == '1);
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
        div_trial = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        div_ge    = div_trial >= {1'b0, b_reg};
        div_diff  = div_trial[XLEN-1:0] - b_reg;
        if (op_q[2])
            prod_step = {(div_ge ? div_diff : div_trial[XLEN-1:0]), prod[XLEN-2:0], div_ge};
        else
            prod_step = {mul_sum, prod[XLEN-1:1]};
    end

    // Sign fix-up, output select and W sign extension for FIX
    always_comb begin
        mul_raw = word_q ? {{HALF{1'b0}}, prod[2*XLEN-1:HALF]} : prod;
        mul_s   = neg ? (~mul_raw + 1'b1) : mul_raw;
        quo_s   = neg ? (~prod[XLEN-1:0] + 1'b1) : prod[XLEN-1:0];
        rem_s   = neg ? (~prod[2*XLEN-1:XLEN] + 1'b1) : prod[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:          res_sel = mul_s[XLEN-1:0];
            3'b100, 3'b101:  res_sel = quo_s;
            3'b110, 3'b111:  res_sel = rem_s;
            default:         res_sel = mul_s[2*XLEN-1:XLEN];
        endcase
        res_fin = word_q ? {{HALF{res_sel[HALF-1]}}, res_sel[HALF-1:0]} : res_sel;
    end

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            rd_addr_out <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            a_raw       <= '0;
            b_raw       <= '0;
            rd_q        <= '0;
            b_reg       <= '0;
            prod        <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
        end else if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state  <= S_PREP;
                        busy   <= 1'b1;
                        op_q   <= op;
                        word_q <= word_eff;
                        a_raw  <= rs1_data;
                        b_raw  <= rs2_data;
                        rd_q   <= rd_addr_in;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (div_zero) begin
                        prod  <= {ext_a, {XLEN{1'b1}}};
                        neg   <= 1'b0;
                        state <= S_FIX;
                    end else if (div_ovf) begin
                        prod  <= {{XLEN{1'b0}}, ext_a};
                        neg   <= 1'b0;
                        state <= S_FIX;
                    end else begin
                        b_reg <= abs_b;
                        neg   <= neg_prep;
                        // W divides start with the dividend in the top half so the
                        // first 32 shifts consume its bits
                        if (op_q[2] && word_q)
                            prod <= {{XLEN{1'b0}}, abs_a[HALF-1:0], {HALF{1'b0}}};
                        else
                            prod <= {{XLEN{1'b0}}, abs_a};
                        cnt   <= word_q ? 7'd32 : 7'd64;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    prod <= prod_step;
                    cnt  <= cnt - 7'd1;
                    if (cnt == 7'd1)
                        state <= S_FIX;
                end
                S_FIX: begin
                    result      <= res_fin;
                    rd_addr_out <= rd_q;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, busy/done timing, kill and async reset.
// Latency: counted in cycles from the accepting edge to the cycle where done is sampled high.
// Backpressure: start is held or pulsed to probe acceptance in DONE and rejection while busy.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic        is_word;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;
    int lat;
    int bcyc;
    int seen_done;

    muldiv_unit #(.XLEN(64)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .kill       (kill),
        .op         (op),
        .is_word    (is_word),
        .rs1_data   (rs1),
        .rs2_data   (rs2),
        .rd_addr_in (rd_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_addr_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present an operation and let the next rising edge accept it
    task automatic launch(input logic [2:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        op = o; is_word = w; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
    endtask

    // Wait (bounded) for done; optionally inject a stray start pulse at cycle pulse_at
    task automatic wait_done(input int pulse_at, output int l, output int bc);
        l  = 0;
        bc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                l = c;
                break;
            end
            if (busy) bc++;
            if (c == pulse_at) begin
                start = 1'b1; op = 3'b011; rs1 = '1; rs2 = '1; rd_in = 5'd31;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp_res, input int exp_lat);
        launch(o, w, a, b, rd);
        wait_done(0, lat, bcyc);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_rd"}, {59'd0, rd_out}, {59'd0, rd});
        @(negedge clk);
        check({tag, "_done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; kill = 1'b0; op = '0; is_word = 1'b0;
        rs1 = '0; rs2 = '0; rd_in = '0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_rd", {59'd0, rd_out}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // MUL 7 * -3 with busy-duration check
        launch(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
        wait_done(0, lat, bcyc);
        check("mul_lat", 64'(lat), 64'd67);
        check("mul_busy_cycles", 64'(bcyc), 64'd66);
        check("mul_res", result, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul_rd", {59'd0, rd_out}, 64'd5);
        check("mul_busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("mul_done_width", {63'd0, done}, 64'd0);

        run("mulhu", 3'b011, 1'b0, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 67);
        run("mulh",  3'b001, 1'b0, '1, '1, 5'd7, 64'd0, 67);
        run("div",   3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8, 64'hFFFF_FFFF_FFFF_FFFA, 67);
        run("rem",   3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 67);
        run("divu0", 3'b101, 1'b0, 64'd100, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run("remu0", 3'b111, 1'b0, 64'd100, 64'd0, 5'd11, 64'd100, 3);
        run("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd12,
            64'hFFFF_FFFF_8000_0000, 3);
        run("remw_ovf", 3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd13,
            64'd0, 3);
        run("mulw", 3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFE, 35);

        // Stray start pulse in the middle of CALC must be ignored
        launch(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd15);
        wait_done(20, lat, bcyc);
        check("ign_lat", 64'(lat), 64'd67);
        check("ign_res", result, 64'hFFFF_FFFF_FFFF_FFEB);
        check("ign_rd", {59'd0, rd_out}, 64'd15);
        @(negedge clk);
        check("ign_idle_busy", {63'd0, busy}, 64'd0);

        // Back-to-back: start held high, second op accepted in the DONE cycle
        @(negedge clk);
        op = 3'b101; is_word = 1'b0; rs1 = 64'd100; rs2 = 64'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        check("b2b1_lat", 64'(lat), 64'd67);
        check("b2b1_res", result, 64'd14);
        check("b2b1_rd", {59'd0, rd_out}, 64'd3);
        op = 3'b111; rd_in = 5'd4;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_width", {63'd0, done}, 64'd0);
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        lat = 0;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        check("b2b2_lat", 64'(lat), 64'd67);
        check("b2b2_res", result, 64'd2);
        check("b2b2_rd", {59'd0, rd_out}, 64'd4);
        @(negedge clk);
        check("b2b2_done_width", {63'd0, done}, 64'd0);

        // kill at CALC cycle 10: back to IDLE, no done, result untouched
        launch(3'b000, 1'b0, 64'd7, 64'd9, 5'd20);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {63'd0, busy}, 64'd0);
        check("kill_done", {63'd0, done}, 64'd0);
        check("kill_res", result, 64'd2);
        seen_done = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("kill_no_done", 64'(seen_done), 64'd0);
        check("kill_res_late", result, 64'd2);

        // kill has priority over start in the same cycle
        @(negedge clk);
        op = 3'b000; rs1 = 64'd3; rs2 = 64'd3; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_vs_start_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of CALC
        launch(3'b000, 1'b0, 64'd7, 64'd9, 5'd21);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_res", result, 64'd0);
        check("arst_rd", {59'd0, rd_out}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run("post_rst_mulw", 3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd22,
            64'hFFFF_FFFF_FFFF_FFFE, 35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
